// File: rtl/ir_frame_decoder_if.sv
// ir_frame_decoder_if -- button-code output handshake of the IR frame decoder.
//   btn_code  : decoded button code (producer -> consumer)
//   btn_valid : btn_code is available (producer -> consumer)
//   btn_ready : consumer accepts btn_code (consumer -> producer)
// master = decoder side, slave = consumer side.
interface ir_frame_decoder_if;
  logic [7:0] btn_code;
  logic       btn_valid;
  logic       btn_ready;

  modport master (output btn_code, output btn_valid, input btn_ready);
  modport slave  (input btn_code, input btn_valid, output btn_ready);
endinterface

// File: rtl/ir_frame_decoder.sv
// ir_frame_decoder -- pulse-distance IR remote frame decoder.
// Decodes a leader (long mark + space) followed by CODE_W bits sent LSB
// first, where the space length after each mark carries the bit value.
// The upper CODE_W-8 bits must equal ADDR; the low 8 bits are a command
// translated through a fixed table into a button code held on a
// valid/ready output.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ir_rx       : demodulated IR line, asynchronous, idle high, mark low
//   btn         : button output handshake (btn_code/btn_valid/btn_ready)
//   err_timeout : 1-cycle pulse, frame aborted because a phase ran too long
//   err_frame   : 1-cycle pulse, complete frame with bad address/command
//   overflow    : 1-cycle pulse, good frame dropped, output still occupied
module ir_frame_decoder #(
  parameter int                CODE_W     = 16,
  parameter logic [CODE_W-9:0] ADDR       = (CODE_W-8)'(8'h0A),
  parameter int                TICK_DIV   = 2700,
  parameter int                LEAD_MIN   = 160,
  parameter int                BIT_THRESH = 20,
  parameter int                TIMEOUT    = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ir_rx,
  ir_frame_decoder_if.master  btn,
  output logic                err_timeout,
  output logic                err_frame,
  output logic                overflow
);

  localparam int PRE_W = $clog2(TICK_DIV + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = $clog2(CODE_W);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LEAD_C    = CNT_W'(LEAD_MIN);
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CODE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_EMIT
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic                prev_q, prev_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CODE_W-1:0]   shift_q, shift_d;
  logic [7:0]          btn_code_q, btn_code_d;
  logic                btn_valid_q, btn_valid_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_frame_q, err_frame_d;
  logic                overflow_q, overflow_d;

  logic                tick, fall, rise;
  logic [8:0]          map_res;
  logic                addr_ok;

  // Returns {hit, button_code}; hit=0 for commands outside the table.
  function automatic logic [8:0] map_cmd(input logic [7:0] cmd);
    case (cmd)
      8'h0B:   return {1'b1, 8'h01};
      8'h02:   return {1'b1, 8'h02};
      8'h04:   return {1'b1, 8'h05};
      8'h06:   return {1'b1, 8'h06};
      8'h08:   return {1'b1, 8'h07};
      8'h10:   return {1'b1, 8'h08};
      8'h0A:   return {1'b1, 8'h09};
      8'h12:   return {1'b1, 8'h0A};
      default: return 9'h000;
    endcase
  endfunction

  // Edges are taken only from the synchronized line (sync_q[1]) against its
  // one-cycle-delayed copy, so a metastable first stage never reaches the FSM.
  assign tick    = (pre_q == PRE_LAST);
  assign fall    = prev_q & ~sync_q[1];
  assign rise    = ~prev_q & sync_q[1];
  assign map_res = map_cmd(shift_q[7:0]);
  assign addr_ok = (shift_q[CODE_W-1:8] == ADDR);

  always_comb begin
    state_d       = state_q;
    sync_d        = {sync_q[0], ir_rx};
    prev_d        = sync_q[1];
    pre_d         = tick ? '0 : pre_q + 1'b1;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    btn_code_d    = btn_code_q;
    btn_valid_d   = btn_valid_q;
    err_timeout_d = 1'b0;
    err_frame_d   = 1'b0;
    overflow_d    = 1'b0;

    // Phase length in ticks since the last line edge, saturating.
    if (fall | rise)                      cnt_d = '0;
    else if (tick && cnt_q != TIMEOUT_C)  cnt_d = cnt_q + 1'b1;

    if (btn_valid_q && btn.btn_ready) btn_valid_d = 1'b0;

    case (state_q)
      S_IDLE:       if (fall) state_d = S_LEAD_MARK;
      S_LEAD_MARK:  if (rise) state_d = (cnt_q >= LEAD_C) ? S_LEAD_SPACE : S_IDLE;
      S_LEAD_SPACE: if (fall) begin
        state_d = S_BIT_MARK;
        idx_d   = '0;
        shift_d = '0;
      end
      S_BIT_MARK:   if (rise) state_d = S_BIT_SPACE;
      S_BIT_SPACE:  if (fall) begin
        // LSB arrives first, so shift in from the top.
        shift_d = {(cnt_q > THRESH_C), shift_q[CODE_W-1:1]};
        if (idx_q == IDX_LAST) state_d = S_EMIT;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_BIT_MARK;
        end
      end
      S_EMIT: begin
        state_d = S_IDLE;
        if (!addr_ok || !map_res[8]) err_frame_d = 1'b1;
        else if (!btn_valid_q || btn.btn_ready) begin
          btn_code_d  = map_res[7:0];
          btn_valid_d = 1'b1;
        end else overflow_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A stuck phase anywhere inside a frame abandons it.
    if (state_q != S_IDLE && state_q != S_EMIT && cnt_q == TIMEOUT_C) begin
      state_d       = S_IDLE;
      err_timeout_d = 1'b1;
      idx_d         = '0;
      shift_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sync_q        <= 2'b11;
      prev_q        <= 1'b1;
      pre_q         <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      btn_code_q    <= '0;
      btn_valid_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_frame_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      pre_q         <= pre_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      btn_code_q    <= btn_code_d;
      btn_valid_q   <= btn_valid_d;
      err_timeout_q <= err_timeout_d;
      err_frame_q   <= err_frame_d;
      overflow_q    <= overflow_d;
    end
  end

  assign btn.btn_code  = btn_code_q;
  assign btn.btn_valid = btn_valid_q;
  assign err_timeout   = err_timeout_q;
  assign err_frame     = err_frame_q;
  assign overflow      = overflow_q;

endmodule
